// File: rtl/obstacle_spawner.sv
// Obstacle scheduler: takes one random byte per obstacle, waits a speed-scaled
// random number of game ticks, then pulses spawn with the type/height from that byte.
module obstacle_spawner #(
    parameter int MIN_GAP  = 40,
    parameter int GAP_BITS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       tick,
    input  logic [1:0] speed_lvl,
    input  logic [7:0] rnd,
    output logic       rnd_take,
    output logic       spawn,
    output logic [1:0] obs_type,
    output logic [1:0] obs_height,
    output logic [7:0] spawn_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, COUNT, SPAWN} state_t;

    localparam logic [8:0] MIN_GAP_W = 9'(MIN_GAP);
    localparam logic [7:0] RND_MASK  = 8'((1 << GAP_BITS) - 1);

    state_t     state_reg, state_next;
    logic [8:0] gap_cnt_reg, gap_cnt_next;
    logic [7:0] byte_reg, byte_next;
    logic [1:0] type_next, height_next;
    logic [7:0] cnt_next;
    logic [8:0] base_gap, rnd_gap;

    assign base_gap = MIN_GAP_W >> speed_lvl;
    assign rnd_gap  = {1'b0, rnd & RND_MASK};

    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        byte_next    = byte_reg;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:  state_next = LOAD;
                LOAD: begin
                    byte_next    = rnd;
                    gap_cnt_next = base_gap + rnd_gap;
                    state_next   = COUNT;
                end
                COUNT: begin
                    if (tick) begin
                        gap_cnt_next = gap_cnt_reg - 9'd1;
                        // <= 1 also guards against a zero gap wrapping the counter
                        if (gap_cnt_reg <= 9'd1) begin
                            gap_cnt_next = 9'd0;
                            state_next   = SPAWN;
                        end
                    end
                end
                SPAWN: state_next = LOAD;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so every output is a plain register.
    always_comb begin
        type_next   = obs_type;
        height_next = obs_height;
        cnt_next    = spawn_cnt;
        if (state_next == SPAWN) begin
            type_next = byte_next[7:6];
            if (byte_next[7:6] == 2'b11)
                height_next = byte_next[5] ? 2'd2 : {1'b0, byte_next[4]};
            else
                height_next = 2'd0;
            cnt_next = spawn_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            gap_cnt_reg <= 9'd0;
            byte_reg    <= 8'd0;
            rnd_take    <= 1'b0;
            spawn       <= 1'b0;
            obs_type    <= 2'd0;
            obs_height  <= 2'd0;
            spawn_cnt   <= 8'd0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
            byte_reg    <= byte_next;
            rnd_take    <= (state_next == LOAD);
            spawn       <= (state_next == SPAWN);
            obs_type    <= type_next;
            obs_height  <= height_next;
            spawn_cnt   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Scoreboard bench: the driver predicts each rnd_take/spawn event from an
// event-level model and queues it; a negedge monitor pops and compares.
module tb_obstacle_spawner;

    localparam int MIN_GAP  = 40;
    localparam int GAP_BITS = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] speed_lvl = 2'd0;
    logic [7:0] rnd = 8'd0;
    logic       rnd_take, spawn;
    logic [1:0] obs_type, obs_height;
    logic [7:0] spawn_cnt;

    obstacle_spawner #(.MIN_GAP(MIN_GAP), .GAP_BITS(GAP_BITS)) dut (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick),
        .speed_lvl(speed_lvl), .rnd(rnd), .rnd_take(rnd_take), .spawn(spawn),
        .obs_type(obs_type), .obs_height(obs_height), .spawn_cnt(spawn_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        bit         is_spawn;
        logic [1:0] typ;
        logic [1:0] hgt;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Model: what the spawner is doing in the current cycle.
    localparam int A_NONE = 0, A_TAKE = 1, A_WAIT = 2, A_EMIT = 3;
    int act       = A_NONE;
    int ticks_left = 0;
    int held_byte = 0;
    int m_cnt     = 0;

    // Called once per cycle after inputs are driven; predicts the next cycle.
    task automatic predict();
        exp_t e;
        int nxt;
        nxt = act;
        if (!rst) begin
            nxt = A_NONE;
            m_cnt = 0;
            exp_q.delete();
        end else if (!enable) begin
            nxt = A_NONE;
        end else begin
            if (act == A_NONE || act == A_EMIT) begin
                nxt = A_TAKE;
            end else if (act == A_TAKE) begin
                held_byte  = int'(rnd);
                ticks_left = (MIN_GAP >> speed_lvl) + (int'(rnd) % (1 << GAP_BITS));
                nxt = A_WAIT;
            end else if (tick) begin
                ticks_left = ticks_left - 1;
                if (ticks_left <= 0) nxt = A_EMIT;
            end
        end
        if (nxt == A_TAKE) begin
            e.at = cyc + 1; e.is_spawn = 1'b0; e.typ = 2'd0; e.hgt = 2'd0; e.cnt = 8'd0;
            exp_q.push_back(e);
        end else if (nxt == A_EMIT) begin
            m_cnt = (m_cnt + 1) % 256;
            e.at = cyc + 1;
            e.is_spawn = 1'b1;
            e.typ = 2'((held_byte / 64) % 4);
            if (e.typ == 2'd3)
                e.hgt = ((held_byte / 32) % 2 == 1) ? 2'd2 : 2'((held_byte / 16) % 2);
            else
                e.hgt = 2'd0;
            e.cnt = 8'(m_cnt);
            exp_q.push_back(e);
        end
        act = nxt;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            e = exp_q.pop_front();
            total++; bad++;
            $display("FAIL stale_event: cycle %0d spawn=%0b never seen", e.at, e.is_spawn);
        end
        if (rnd_take || spawn) begin
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                e = exp_q.pop_front();
                total++;
                if (!e.is_spawn) begin
                    if ({rnd_take, spawn} != 2'b10) begin
                        bad++;
                        $display("FAIL take_event: cycle %0d got take=%0b spawn=%0b want take=1 spawn=0",
                                 cyc, rnd_take, spawn);
                    end
                end else if ({rnd_take, spawn, obs_type, obs_height, spawn_cnt} !=
                             {1'b0, 1'b1, e.typ, e.hgt, e.cnt}) begin
                    bad++;
                    $display("FAIL spawn_event: cycle %0d got take=%0b spawn=%0b type=%0d h=%0d cnt=%0d want spawn type=%0d h=%0d cnt=%0d",
                             cyc, rnd_take, spawn, obs_type, obs_height, spawn_cnt, e.typ, e.hgt, e.cnt);
                end
            end else begin
                total++; bad++;
                $display("FAIL unexpected_output: cycle %0d got take=%0b spawn=%0b, want none",
                         cyc, rnd_take, spawn);
            end
        end else if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
            e = exp_q.pop_front();
            total++; bad++;
            $display("FAIL missing_output: cycle %0d got nothing, want spawn=%0b", cyc, e.is_spawn);
        end
    end

    // en: 0/1 fixed, 2 = random drops; tmode: 0 none, 1 always, 2 random, 4 every 4th cycle;
    // spd/rv < 0 means random.
    task automatic phase(input int n, input int en, input int tmode, input int spd, input int rv);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            enable = (en == 2) ? ($urandom_range(0, 63) != 0) : (en != 0);
            case (tmode)
                0:       tick = 1'b0;
                1:       tick = 1'b1;
                4:       tick = (cyc % 4 == 0);
                default: tick = 1'($urandom_range(0, 1));
            endcase
            speed_lvl = (spd < 0) ? 2'($urandom_range(0, 3)) : 2'(spd);
            rnd = (rv < 0) ? 8'($urandom_range(0, 255)) : 8'(rv);
            predict();
        end
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            predict();
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({rnd_take, spawn, obs_type, obs_height, spawn_cnt} != 14'd0) begin
            bad++;
            $display("FAIL %s: got take=%0b spawn=%0b type=%0d h=%0d cnt=%0d want all 0",
                     name, rnd_take, spawn, obs_type, obs_height, spawn_cnt);
        end
    endtask

    initial begin
        #1;
        check_zero("reset_no_clock");
        hold_reset(2);
        phase(200, 1, 4, 0, 8'h05);      // gap 45, tick every 4th cycle
        phase(100, 1, 1, 2, 8'hE0);      // bird, height 2
        // Asynchronous reset mid-count, observed before any further edge
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_zero("reset_mid_count");
        predict();
        hold_reset(1);
        phase(150, 1, 1, 3, 8'h3F);      // gap 68, period 70
        phase(80, 1, 4, 0, 8'h00);       // abort partway through the count
        phase(3, 0, 4, 0, 8'h00);
        phase(200, 1, 4, 0, 8'h00);      // fresh gap of 40 ticks
        phase(256 * 7 + 20, 1, 1, 3, 8'h00);  // >256 spawns: counter wraps
        phase(3000, 2, 2, -1, -1);       // randomized
        phase(5, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (spawn_cnt != 8'(m_cnt)) begin
            bad++;
            $display("FAIL final_spawn_cnt: got %0d want %0d", spawn_cnt, m_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
